// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU and debug ports, one fixed-latency access at a time.
// Ties go to debug; define MEM_ARB_RR_EN to break ties round-robin instead.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, we_q, we_d, cpu_ack_q, cpu_ack_d, dbg_ack_q, dbg_ack_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic grant_dbg;
`ifdef MEM_ARB_RR_EN
  logic last_dbg_q, last_dbg_d;
  assign grant_dbg = dbg_req & (~cpu_req | ~last_dbg_q);
  always_comb last_dbg_d = (state_q == IDLE && (cpu_req || dbg_req)) ? grant_dbg : last_dbg_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_dbg_q <= 1'b1;
    else last_dbg_q <= last_dbg_d;
`else
  assign grant_dbg = dbg_req;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: if (cpu_req || dbg_req) begin
        state_d = ISSUE;
        owner_d = grant_dbg;
        we_d = grant_dbg ? dbg_we : cpu_we;
        addr_d = grant_dbg ? dbg_addr : cpu_addr;
        wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
      end
      ISSUE: begin
        state_d = we_q ? RESP : WAIT;
        cnt_d = we_q ? cnt_q : 4'(MEM_LAT);
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cpu_rdata_d = owner_q ? cpu_rdata_q : mem_rdata;
          dbg_rdata_d = owner_q ? mem_rdata : dbg_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // RESP is only ever entered from ISSUE or WAIT, so the ack is raised on entry
    cpu_ack_d = (state_d == RESP) && (state_q != RESP) && !owner_q;
    dbg_ack_d = (state_d == RESP) && (state_q != RESP) && owner_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_ack_q <= cpu_ack_d;
      dbg_ack_q <= dbg_ack_d;
    end
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_ack = cpu_ack_q;
  assign dbg_ack = dbg_ack_q;
  assign mem_en = state_q == ISSUE;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign busy = state_q != IDLE;
  assign owner = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, multi-cycle corner sequences and a transaction-level random model for mem_arbiter.
module tb_mem_arbiter;
  localparam int LAT = 3;
  logic clk = 1'b0, rst = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_ack, dbg_ack, mem_en, mem_we, busy, owner;
  int n_vec = 0, n_err = 0, edge_n = 0;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Memory macro: preset contents plus a write overlay; read data valid only LAT cycles after mem_en
  logic [31:0] ovl [1024];
  logic [1023:0] wr_v = '0;
  logic [LAT-1:0] pv = '0;
  logic [31:0] pd [LAT];
  function automatic logic [31:0] base(input int i);
    return (i == 16) ? 32'hDEADBEEF : 32'h1000_0000 + i;
  endfunction
  function automatic logic [31:0] rdm(input int i);
    return wr_v[i] ? ovl[i] : base(i);
  endfunction
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    pv[0] <= mem_en && !mem_we;
    pd[0] <= rdm(int'(mem_addr[11:2]));
    if (mem_en && mem_we) begin
      ovl[mem_addr[11:2]] <= mem_wdata;
      wr_v[mem_addr[11:2]] <= 1'b1;
    end
  end
  assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0_BAD0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic dbg;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int lat;
    logic [31:0] own_rd;
    logic [31:0] oth_rd;
  } vec_t;

  task automatic do_txn(input string nm, input vec_t v);
    int en_at, en_cnt, ack_at, bad_ack;
    logic [31:0] ea, ed;
    logic ew;
    en_at = -1; en_cnt = 0; ack_at = -1; bad_ack = 0; ea = '0; ed = '0; ew = 1'b0;
    @(negedge clk);
    if (v.dbg) begin
      dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int k = 1; k <= 20 && ack_at < 0; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (en_at < 0) begin en_at = k; ea = mem_addr; ed = mem_wdata; ew = mem_we; end
      end
      if (v.dbg ? cpu_ack : dbg_ack) bad_ack++;
      if (v.dbg ? dbg_ack : cpu_ack) begin
        ack_at = k;
        chk({nm, "_rd_at_ack"}, v.dbg ? dbg_rdata : cpu_rdata, v.own_rd);
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk({nm, "_lat"}, ack_at, v.lat);
    chk({nm, "_en_at"}, en_at, 1);
    chk({nm, "_en_cnt"}, en_cnt, 1);
    chk({nm, "_mem_fields"}, {ew, ea, ed}, {v.we, v.addr, v.wdata});
    chk({nm, "_other_ack"}, bad_ack, 0);
    @(negedge clk);
    chk({nm, "_own_rd_held"}, v.dbg ? dbg_rdata : cpu_rdata, v.own_rd);
    chk({nm, "_oth_rd"}, v.dbg ? cpu_rdata : dbg_rdata, v.oth_rd);
    chk({nm, "_idle"}, {busy, owner, cpu_ack, dbg_ack}, {1'b0, v.dbg, 2'b00});
  endtask

  vec_t tbl [9];
  vec_t rv;
  logic [3:0] order, exp_order;
  logic [1:0] pend;
  logic rq_we [2];
  logic [31:0] rq_addr [2], rq_wd [2], mm [16];
  logic [31:0] ga, gd, exp_rd, m_cpu, m_dbg;
  logic gw;
  int cnt, seen, cpu_ack_at, dbg_en_at, dbg_ack_at, en_cnt, w, last, tie_w, g, a, e_next, n;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 32'h040, 32'h0000_0000, 2 + LAT, 32'hDEADBEEF, 32'h0000_0000};
    tbl[1] = '{1'b1, 1'b1, 32'h100, 32'h1234_5678, 2,       32'h0000_0000, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 32'h100, 32'h0000_0000, 2 + LAT, 32'h1234_5678, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 32'h040, 32'hCAFE_F00D, 2,       32'hDEADBEEF, 32'h1234_5678};
    tbl[4] = '{1'b0, 1'b0, 32'h040, 32'h0000_0000, 2 + LAT, 32'hCAFE_F00D, 32'h1234_5678};
    tbl[5] = '{1'b1, 1'b0, 32'h200, 32'h0000_0000, 2 + LAT, 32'h1000_0080, 32'hCAFE_F00D};
    tbl[6] = '{1'b0, 1'b0, 32'h3FC, 32'h0000_0000, 2 + LAT, 32'h1000_00FF, 32'h1000_0080};
    tbl[7] = '{1'b1, 1'b1, 32'h3FC, 32'hA5A5_5A5A, 2,       32'h1000_0080, 32'h1000_00FF};
    tbl[8] = '{1'b0, 1'b0, 32'h3FC, 32'h0000_0000, 2 + LAT, 32'hA5A5_5A5A, 32'h1000_0080};
`ifdef MEM_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1111;
`endif
    @(negedge clk);
    chk("por_outs", {mem_en, mem_we, cpu_ack, dbg_ack, busy, owner}, 6'b0);
    chk("por_regs", {mem_addr, cpu_rdata}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) do_txn($sformatf("t%0d", i), tbl[i]);

    // Reset in the middle of a CPU read wait phase
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h040; cpu_wdata = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_outs", {mem_en, mem_we, cpu_ack, dbg_ack, busy, owner}, 6'b0);
    chk("rst_mem", {mem_addr, mem_wdata}, 64'h0);
    chk("rst_rdata", {cpu_rdata, dbg_rdata}, 64'h0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen += int'(cpu_ack | dbg_ack | mem_en | busy);
    end
    chk("rst_quiet", seen, 0);
    cpu_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_idle", busy, 1'b0);

    // Both requesters read continuously
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h040;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h100;
    cnt = 0; order = '0;
    for (int k = 0; k < 80 && cnt < 4; k++) begin
      @(negedge clk);
      if (cpu_ack) begin order[cnt] = 1'b0; cnt++; end
      if (dbg_ack && cnt < 4) begin order[cnt] = 1'b1; cnt++; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("tie_count", cnt, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("tie_grant%0d", i), order[i], exp_order[i]);
    @(negedge clk);
    rv = '{1'b0, 1'b0, 32'h040, 32'h0000_0000, 2 + LAT, 32'hCAFE_F00D, 32'h1234_5678};
    do_txn("reissue", rv);

    // Debug request arriving while a CPU read waits
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3FC;
    cpu_ack_at = -1; dbg_en_at = -1; dbg_ack_at = -1; en_cnt = 0;
    for (int k = 1; k <= 40 && dbg_ack_at < 0; k++) begin
      @(negedge clk);
      if (k == 2) begin dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h200; end
      if (mem_en) begin
        en_cnt++;
        if (en_cnt == 1) chk("late_cpu_issue", {k, mem_addr}, {32'd1, 32'h3FC});
        if (en_cnt == 2) begin
          dbg_en_at = k;
          chk("late_dbg_issue", {owner, mem_addr}, {1'b1, 32'h200});
        end
      end
      if (cpu_ack) begin
        cpu_ack_at = k;
        cpu_req = 1'b0;
        chk("late_cpu_rd", cpu_rdata, 32'hA5A5_5A5A);
      end
      if (dbg_ack) dbg_ack_at = k;
    end
    dbg_req = 1'b0;
    chk("late_cpu_ack_at", cpu_ack_at, 2 + LAT);
    chk("late_dbg_en_at", dbg_en_at, 4 + LAT);
    chk("late_dbg_ack_at", dbg_ack_at, 5 + 2 * LAT);
    chk("late_dbg_rd", dbg_rdata, 32'h1000_0080);
    @(negedge clk);

    // Random traffic against a transaction-level model
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 16; j++) mm[j] = 32'h1000_0200 + j;
    pend = 2'b00; w = 0; last = 1; g = -10; a = -10; gw = 1'b0; ga = '0; gd = '0;
    exp_rd = '0; m_cpu = '0; m_dbg = '0;
    for (int r = 0; r < 2; r++) begin rq_we[r] = 1'b0; rq_addr[r] = '0; rq_wd[r] = '0; end
    e_next = edge_n + 1;
    for (int it = 0; it < 2500; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (pend[r] && edge_n == a && w == r) pend[r] = 1'b0;
        if (!pend[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[r] = 1'b1;
            rq_we[r] = 1'($urandom_range(0, 1));
            rq_addr[r] = 32'h800 + 32'($urandom_range(0, 15) << 2);
            rq_wd[r] = $urandom;
          end
        end else if (w == r && edge_n >= g && edge_n < a && $urandom_range(0, 2) == 0) begin
          rq_we[r] = 1'($urandom_range(0, 1));
          rq_addr[r] = $urandom;
          rq_wd[r] = $urandom;
        end
      end
      cpu_req = pend[0]; cpu_we = rq_we[0]; cpu_addr = rq_addr[0]; cpu_wdata = rq_wd[0];
      dbg_req = pend[1]; dbg_we = rq_we[1]; dbg_addr = rq_addr[1]; dbg_wdata = rq_wd[1];
      if (edge_n + 1 == e_next) begin
        if (pend != 2'b00) begin
`ifdef MEM_ARB_RR_EN
          tie_w = 1 - last;
`else
          tie_w = 1;
`endif
          w = (pend == 2'b11) ? tie_w : int'(pend[1]);
          last = w; g = e_next; gw = rq_we[w]; ga = rq_addr[w]; gd = rq_wd[w];
          a = g + (gw ? 1 : 1 + LAT);
          if (gw) mm[ga[5:2]] = gd;
          else exp_rd = mm[ga[5:2]];
          e_next = a + 2;
        end else e_next++;
      end
      @(negedge clk);
      n = edge_n;
      if (n == a && !gw) begin
        if (w == 1) m_dbg = exp_rd;
        else m_cpu = exp_rd;
      end
      chk("r_mem_en", mem_en, n == g);
      if (n == g) chk("r_mem_fields", {mem_we, mem_addr, mem_wdata}, {gw, ga, gd});
      chk("r_acks", {cpu_ack, dbg_ack}, {n == a && w == 0, n == a && w == 1});
      chk("r_cpu_rdata", cpu_rdata, m_cpu);
      chk("r_dbg_rdata", dbg_rdata, m_dbg);
      chk("r_busy_owner", {busy, owner}, {n >= g && n <= a, w == 1});
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
